// File: rtl/procesador_risc_v.sv
// procesador_risc_v: single-cycle RV64I-subset core (ld/sd/add/sub/and/or/beq)
// running a hard-coded looping program from an internal ROM.
module procesador_risc_v #(
    parameter int Bits    = 64,
    parameter int MemSize = 16,
    parameter int N       = 32,
    parameter int NumInst = 7
) (
    input logic clk,
    input logic rst
);
    localparam int AW = $clog2(MemSize);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] PROG [7] = '{
        32'h0180_3503,
        32'h0025_05B3,
        32'h4045_8633,
        32'h0075_F6B3,
        32'h0086_6733,
        32'h02E0_3023,
        32'hFE00_04E3
    };
    logic [Bits-1:0] pc;
    logic [Bits-1:0] reg_file [N];
    logic [Bits-1:0] data_mem [MemSize];
    logic [Bits-3:0] wi;
    logic [31:0] inst;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic is_ld, is_sd, is_beq, is_r, r_add, r_sub, r_and, r_or, we;
    logic [Bits-1:0] a, b, imm, alu, wd, pc_next;
    always_comb begin
        wi      = pc[Bits-1:2];
        inst    = wi < (Bits-2)'(NumInst) ? PROG[wi[2:0]] : NOP;
        op      = inst[6:0];
        f3      = inst[14:12];
        f7      = inst[31:25];
        is_ld   = op == 7'b0000011 && f3 == 3'b011;
        is_sd   = op == 7'b0100011 && f3 == 3'b011;
        is_beq  = op == 7'b1100011 && f3 == 3'b000;
        is_r    = op == 7'b0110011;
        r_add   = is_r && f3 == 3'b000 && f7 == 7'b0000000;
        r_sub   = is_r && f3 == 3'b000 && f7 == 7'b0100000;
        r_and   = is_r && f3 == 3'b111;
        r_or    = is_r && f3 == 3'b110;
        a       = reg_file[inst[19:15]];
        b       = reg_file[inst[24:20]];
        imm     = is_sd  ? {{(Bits-12){inst[31]}}, inst[31:25], inst[11:7]} :
                  is_beq ? {{(Bits-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
                           {{(Bits-12){inst[31]}}, inst[31:20]};
        // loads and stores share the adder path for rs1+imm
        alu     = r_sub ? a - b : r_and ? a & b : r_or ? a | b : r_add ? a + b : a + imm;
        wd      = is_ld ? data_mem[alu[3 +: AW]] : alu;
        we      = (is_ld || r_add || r_sub || r_and || r_or) && inst[11:7] != 5'd0;
        pc_next = is_beq && a == b ? pc + imm : pc + Bits'(4);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
            for (int i = 0; i < N; i++) reg_file[i] <= Bits'(i);
            for (int i = 0; i < MemSize; i++) data_mem[i] <= Bits'(i);
        end else begin
            pc <= pc_next;
            if (we) reg_file[inst[11:7]] <= wd;
            if (is_sd) data_mem[alu[3 +: AW]] <= b;
        end
    end
endmodule

// File: tb/tb_procesador_risc_v.sv
// tb_procesador_risc_v: scoreboard bench; stimulus queues expected architectural
// state per retired cycle, a monitor compares it against the core's state.
module tb_procesador_risc_v;
    logic clk, rst;
    logic async_chk;
    int edges, tests, fails;
    event mon_ev;
    typedef struct {
        int cyc;
        int kind;
        int idx;
        logic [63:0] val;
        string nm;
    } exp_t;
    exp_t q[$];
    int ri [5] = '{10, 11, 12, 13, 14};
    logic [63:0] rv [5] = '{64'd3, 64'd5, 64'd1, 64'd5, 64'd9};

    procesador_risc_v dut (.clk(clk), .rst(rst));

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst)
        if (rst) edges <= 0;
        else edges <= edges + 1;

    task automatic push(input int cyc, input int kind, input int idx, input logic [63:0] val, input string nm);
        exp_t e;
        e.cyc = cyc; e.kind = kind; e.idx = idx; e.val = val; e.nm = nm;
        q.push_back(e);
    endtask

    function automatic logic [63:0] act(input int kind, input int idx);
        return kind == 0 ? dut.pc : kind == 1 ? dut.reg_file[idx] : dut.data_mem[idx];
    endfunction

    initial begin
        exp_t e;
        logic [63:0] got;
        forever begin
            @(negedge clk or mon_ev);
            while (q.size() > 0 && q[0].cyc == (async_chk ? -1 : edges)) begin
                e = q.pop_front();
                got = act(e.kind, e.idx);
                tests++;
                if (got !== e.val) begin
                    fails++;
                    $display("FAIL %s[%0d] cyc %0d: got %h expected %h", e.nm, e.idx, e.cyc, got, e.val);
                end
            end
        end
    end

    task automatic push_reset(input int cyc);
        push(cyc, 0, 0, 64'd0, "pc");
        push(cyc, 1, 10, 64'd10, "reg");
        push(cyc, 1, 14, 64'd14, "reg");
        push(cyc, 2, 4, 64'd4, "mem");
    endtask

    initial begin
        int j;
        rst = 1; async_chk = 0; tests = 0; fails = 0;
        push_reset(0);
        repeat (3) @(negedge clk);
        #1 push_reset(0);
        @(negedge clk);
        for (int k = 1; k <= 14; k++) begin
            j = (k - 1) % 7;
            push(k, 0, 0, 64'((k % 7) * 4), "pc");
            if (j < 5) push(k, 1, ri[j], rv[j], "reg");
            if (j == 5) push(k, 1, 14, 64'd9, "reg_hold");
            if (j == 5) push(k, 1, 13, 64'd5, "reg_hold");
            push(k, 2, 4, k >= 6 ? 64'd9 : 64'd4, "mem");
        end
        @(posedge clk);
        #2 rst = 0;
        repeat (17) @(posedge clk);
        #2 rst = 1;
        #1 async_chk = 1;
        push_reset(-1);
        ->mon_ev;
        #1 async_chk = 0;
        repeat (2) @(posedge clk);
        #1 push_reset(0);
        @(posedge clk);
        push(1, 0, 0, 64'd4, "pc");
        push(1, 1, 10, 64'd3, "reg");
        push(2, 0, 0, 64'd8, "pc");
        push(2, 1, 11, 64'd5, "reg");
        #2 rst = 0;
        repeat (4) @(negedge clk);
        #1 tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/procesador_risc_v.md
Name: procesador_risc_v

Overview:
- Single-cycle RV64I-subset processor: PC, instruction ROM, 32x64 register file, immediate generator, ALU, data RAM and branch logic.
- Every instruction fetches, executes and retires in one clock.
- Top of the processor design: no external buses; state is observed hierarchically through the signals named under Behaviour.

Parameters:
- Bits, 64, datapath, register and data-memory word width.
- MemSize, 16, number of Bits-wide data-memory words.
- N, 32, number of architectural registers (x0..x(N-1)).
- NumInst, 7, number of 32-bit words in the instruction ROM.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.

Behaviour:
- Reset (asynchronous, active-high), held while rst=1:
  - pc=0.
  - reg_file[i]=i for all i; x0=0.
  - data_mem[i]=i for i in 0..MemSize-1.
- Instruction ROM (read-only, word index pc[..:2]), hard-coded program:
  - 0x00: ld x10,24(x0)
  - 0x04: add x11,x10,x2
  - 0x08: sub x12,x11,x4
  - 0x0C: and x13,x11,x7
  - 0x10: or x14,x12,x8
  - 0x14: sd x14,32(x0)
  - 0x18: beq x0,x0,-24
- Fetch: a word index >= NumInst returns 0x00000013 (NOP).
- Supported encodings (standard RV64I fields):
  - ld: opcode 0000011, funct3 011.
  - sd: opcode 0100011, funct3 011.
  - R-type: opcode 0110011. add: f3 000/f7 0000000. sub: f3 000/f7 0100000. and: f3 111. or: f3 110.
  - beq: opcode 1100011, funct3 000.
  - Any other encoding is a NOP: no register or memory write, pc+=4.
- Immediates:
  - I-type and S-type sign-extended to Bits.
  - B-type = sign-extended {imm[12:1],0}.
- Execution and arithmetic:
  - Register reads are combinational; rd written on the rising edge.
  - Writes to x0 are discarded; x0 always reads 0.
  - ALU is Bits wide; add/sub wrap modulo 2^Bits, no overflow flag.
  - Data address = rs1+imm; word index = addr[..:3] mod MemSize; addr[2:0] ignored.
  - Loads are a combinational read; stores write on the rising edge.
- Next PC:
  - beq taken (rs1==rs2): pc+imm. Otherwise: pc+4.
  - pc is Bits wide and wraps modulo 2^Bits.
- Timing:
  - CPI=1; the result of instruction k is visible after rising edge k+1 following reset release.
  - The program loops forever: the beq returns to 0x00.
- Reset mid-operation: immediate return to reset state regardless of clk; execution restarts at pc=0 on the first rising edge with rst=0.

Test Plan:
- Hold rst=1 with clk toggling -> pc=0, reg_file[10]=10, data_mem[4]=4, no state change.
- Release rst, 1 edge -> x10=3, pc=4.
- After edges 2-5 -> x11=5, x12=1, x13=5, x14=9, pc=0x14.
- Edge 6 (sd) -> data_mem[4]=9, registers unchanged, pc=0x18.
- Edge 7 (beq) -> pc=0; edges 8-14 repeat the loop with the same values (x10=3, data_mem[4]=9).
- Assert rst asynchronously between edges mid-program -> pc=0, reg_file[14]=14, data_mem[4]=4 immediately, without waiting for a clock edge.
